// File: rtl/rr_arb8_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
//   req[7:0]     level request per requester (master -> slave)
//   rel          release strobe from the current owner (master -> slave)
//   gnt[7:0]     one-hot grant, zero when idle (slave -> master)
//   gnt_idx[2:0] encoded owner index, valid while gnt_vld (slave -> master)
//   gnt_vld      any grant active (slave -> master)
//   timeout      one-cycle pulse on forced release (slave -> master)
interface rr_arb8_if;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       timeout;

    modport master (
        output req, rel,
        input  gnt, gnt_idx, gnt_vld, timeout
    );

    modport slave (
        input  req, rel,
        output gnt, gnt_idx, gnt_vld, timeout
    );
endinterface

// File: rtl/rr_arb8.sv
// Round-robin arbiter sharing one resource among 8 requesters.
// The priority search runs downward starting just below the last winner,
// so every requester is eventually served. All outputs are registered.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    rr_arb8_if.slave: req/rel in, gnt/gnt_idx/gnt_vld/timeout out
// Build option: define ARB_TIMEOUT_EN to force a release after MAX_HOLD
// consecutive granted cycles (parameters MAX_HOLD, CNT_W exist only then).
module rr_arb8
`ifdef ARB_TIMEOUT_EN
#(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
)
`endif
(
    input  logic     clk,
    input  logic     rst_n,
    rr_arb8_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] gnt_q,   gnt_d;
    // Owner index; also serves as the rotation pointer ("last winner").
    logic [2:0] idx_q,   idx_d;
    logic       vld_q,   vld_d;
`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    logic       found;
    logic [2:0] win;
    logic [2:0] cand;

    // Rotating priority search: last-1, last-2, ... wrapping, last itself final.
    always_comb begin
        found = 1'b0;
        win   = 3'd0;
        cand  = 3'd0;
        for (int k = 0; k < 8; k++) begin
            cand = 3'(idx_q - 3'(k) - 3'd1);
            if (!found && bus.req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                // rel is meaningless without an owner and is ignored here.
                if (found) begin
                    state_d = BUSY;
                    gnt_d   = 8'b1 << win;
                    idx_d   = win;
                    vld_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                // A normal release outranks the timeout; no preemption.
                if (bus.rel || !bus.req[idx_q]) begin
                    state_d = IDLE;
                    gnt_d   = 8'h00;
                    vld_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    gnt_d     = 8'h00;
                    vld_d     = 1'b0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'h00;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= 8'h00;
            idx_q   <= 3'd0;
            vld_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
`ifdef ARB_TIMEOUT_EN
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arb8.sv
// Scoreboard bench for rr_arb8: stimulus pushes reference-model expectations,
// an independent monitor pops and compares one entry per clock.
module tb_rr_arb8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_arb8_if bus ();

    rr_arb8 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int MAX_HOLD = 16;
`endif

    typedef struct {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       vld;
        logic       to;
        logic       chk_idx;
    } exp_t;

    exp_t exp_q[$];
    int   grant_log[$];
    logic log_en   = 1'b0;
    logic prev_vld = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model: owner (-1 idle), last winner, cycles held so far.
    int m_owner = -1;
    int m_last  = 0;
    int m_held  = 0;

    int seq1[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
    int seq2[4] = '{2, 0, 2, 0};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Drive one cycle of inputs and queue what the outputs must be after the edge.
    task automatic step(input logic r, input logic [7:0] q, input logic l);
        exp_t e;
        bit   found;
        @(negedge clk);
        rst_n   = r;
        bus.req = q;
        bus.rel = l;
        e.to      = 1'b0;
        e.chk_idx = 1'b0;
        if (!r) begin
            m_owner   = -1;
            m_last    = 0;
            m_held    = 0;
            e.chk_idx = 1'b1;
        end else if (m_owner < 0) begin
            found = 0;
            for (int k = 1; k <= 8; k++) begin
                int c;
                c = (m_last - k + 16) % 8;
                if (!found && q[c]) begin
                    found   = 1;
                    m_owner = c;
                    m_last  = c;
                    m_held  = 1;
                end
            end
        end else if (l || !q[m_owner]) begin
            m_owner = -1;
`ifdef ARB_TIMEOUT_EN
        end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            e.to    = 1'b1;
`endif
        end else begin
            m_held++;
        end
        e.vld = (m_owner >= 0);
        e.gnt = e.vld ? 8'(32'd1 << m_owner) : 8'h00;
        e.idx = 3'(m_last);
        if (e.vld) e.chk_idx = 1'b1;
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs shortly after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("gnt",     32'(bus.gnt),     32'(e.gnt));
                chk("gnt_vld", 32'(bus.gnt_vld), 32'(e.vld));
                chk("timeout", 32'(bus.timeout), 32'(e.to));
                if (e.chk_idx) chk("gnt_idx", 32'(bus.gnt_idx), 32'(e.idx));
                if (log_en && bus.gnt_vld === 1'b1 && !prev_vld)
                    grant_log.push_back(int'(bus.gnt_idx));
            end
            prev_vld = (bus.gnt_vld === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        bus.req = 8'h00;
        bus.rel = 1'b0;

        // Rotation through all requesters, rel held high after the first grant.
        step(1'b0, 8'h00, 1'b0);
        grant_log.delete();
        log_en = 1'b1;
        step(1'b1, 8'hFF, 1'b0);
        repeat (16) step(1'b1, 8'hFF, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        log_en = 1'b0;
        chk("seq1_len", 32'(grant_log.size()), 32'd9);
        for (int i = 0; i < 9 && i < grant_log.size(); i++)
            chk("seq1_idx", 32'(grant_log[i]), 32'(seq1[i]));

        // Two requesters alternate.
        grant_log.delete();
        log_en = 1'b1;
        repeat (8) step(1'b1, 8'h05, 1'b1);
        step(1'b0, 8'h00, 1'b0);
        log_en = 1'b0;
        chk("seq2_len", 32'(grant_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            chk("seq2_idx", 32'(grant_log[i]), 32'(seq2[i]));

        // Release together with a new request: one idle cycle, then owner 4.
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h08, 1'b0);
        step(1'b1, 8'h10, 1'b1);
        step(1'b1, 8'h10, 1'b0);
        step(1'b1, 8'h10, 1'b0);

        // Owner drops its request without rel.
        step(1'b0, 8'h00, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        step(1'b1, 8'h20, 1'b0);
        step(1'b1, 8'h00, 1'b0);
        step(1'b1, 8'h00, 1'b0);

        // Reset mid-grant, then MSB priority restored.
        step(1'b1, 8'h40, 1'b0);
        step(1'b1, 8'h40, 1'b0);
        step(1'b0, 8'h40, 1'b0);
        step(1'b1, 8'hFF, 1'b0);
        step(1'b1, 8'hFF, 1'b1);

        // Long hold by a single requester (forced release only in timeout build).
        step(1'b0, 8'h00, 1'b0);
        repeat (120) step(1'b1, 8'h01, 1'b0);

        // Randomized traffic with occasional reset.
        step(1'b0, 8'h00, 1'b0);
        repeat (400) begin
            logic       r;
            logic [7:0] q;
            logic       l;
            r = ($urandom_range(0, 63) != 0);
            q = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom) & 8'($urandom);
            l = ($urandom_range(0, 3) == 0);
            step(r, q, l);
        end

        @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
